// File: rtl/mem_access_unit_if.sv
// Memory-side handshake bundle for mem_access_unit.
// The master modport is used by the unit and the slave modport by the memory.
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: performs load/store handshakes, with a bus-timeout abort.
// Define MISALIGN_TRAP_EN to trap misaligned word/halfword accesses instead of issuing them.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_mem,
  input  logic [2:0]           in_op,
  input  logic [31:0]          in_addr,
  input  logic [31:0]          in_wdata,
  input  logic [31:0]          in_res,
  input  logic [4:0]           in_dest,
  input  logic                 flush,
  output logic                 stall_out,
  mem_access_unit_if.master    bus,
  output logic                 wb_valid,
  output logic [31:0]          wb_data,
  output logic [4:0]           wb_dest,
  output logic                 exc_misalign,
  output logic                 exc_bus,
  output logic [31:0]          exc_addr
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic              we_q;
  logic [4:0]        dest_q;
  logic              killed;
  logic              accept_pass, accept_mem, done, abort;
  logic              misaligned;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic [15:0]       half_sel;
  logic [7:0]        byte_sel;
  logic [31:0]       load_data;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    case (in_op)
      OP_LW, OP_SW:         misaligned = |in_addr[1:0];
      OP_LH, OP_LHU, OP_SH: misaligned = in_addr[0];
      default:              misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    accept_pass = 1'b0;
    accept_mem  = 1'b0;
    done        = 1'b0;
    abort       = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && !flush) begin
          if (!in_mem) begin
            accept_pass = 1'b1;
          end else if (!misaligned) begin
            accept_mem = 1'b1;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (bus.mem_ready) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Stores are placed on their byte lanes by replication; the enables pick the lane.
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = in_wdata;
    case (in_op)
      OP_SH: begin
        lane_be    = in_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{in_wdata[15:0]}};
      end
      OP_SB: begin
        lane_be    = 4'b0001 << in_addr[1:0];
        lane_wdata = {4{in_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    half_sel  = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    byte_sel  = bus.mem_rdata[7:0];
    case (addr_q[1:0])
      2'd1:    byte_sel = bus.mem_rdata[15:8];
      2'd2:    byte_sel = bus.mem_rdata[23:16];
      2'd3:    byte_sel = bus.mem_rdata[31:24];
      default: byte_sel = bus.mem_rdata[7:0];
    endcase
    load_data = bus.mem_rdata;
    case (op_q)
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'h0000, half_sel};
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'h000000, byte_sel};
      default: load_data = bus.mem_rdata;
    endcase
  end

  // A flush seen at any point of the handshake is remembered so the writeback is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      op_q     <= OP_LW;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      dest_q   <= '0;
      killed   <= 1'b0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_dest  <= '0;
      exc_bus  <= 1'b0;
      exc_addr <= '0;
    end else begin
      wb_valid <= 1'b0;
      exc_bus  <= 1'b0;
      if (accept_pass) begin
        wb_valid <= 1'b1;
        wb_data  <= in_res;
        wb_dest  <= in_dest;
      end
      if (accept_mem) begin
        cnt     <= '0;
        op_q    <= in_op;
        addr_q  <= in_addr;
        wdata_q <= lane_wdata;
        be_q    <= lane_be;
        we_q    <= is_store(in_op);
        dest_q  <= in_dest;
        killed  <= 1'b0;
      end
      if (state == BUSY) begin
        cnt <= cnt + 1'b1;
        if (flush) killed <= 1'b1;
      end
      if (done && !is_store(op_q) && !killed && !flush) begin
        wb_valid <= 1'b1;
        wb_data  <= load_data;
        wb_dest  <= dest_q;
      end
      if (abort) begin
        exc_bus  <= 1'b1;
        exc_addr <= addr_q;
      end
`ifdef MISALIGN_TRAP_EN
      if (state == IDLE && in_valid && in_mem && !flush && misaligned) begin
        exc_addr <= in_addr;
      end
`endif
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) exc_misalign <= 1'b0;
    else     exc_misalign <= (state == IDLE) && in_valid && in_mem && !flush && misaligned;
  end
`else
  assign exc_misalign = 1'b0;
`endif

  assign stall_out     = (state == BUSY);
  assign bus.mem_req   = (state == BUSY);
  assign bus.mem_we    = (state == BUSY) && we_q;
  assign bus.mem_be    = (state == BUSY) ? be_q : 4'b0000;
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata = wdata_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum BUSY cycles without mem_ready before bus-error abort.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  EX/MEM slot holds an instruction.
REQ-005 in_mem  input  1  instruction is a load/store; 0 means pass-through.
REQ-006 in_op  input  3  access type: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
REQ-007 in_addr  input  32  effective byte address from ALU.
REQ-008 in_wdata  input  32  store data, unaligned (bits [7:0] / [15:0] / [31:0]).
REQ-009 in_res  input  32  ALU result for pass-through instructions.
REQ-010 in_dest  input  5  writeback register index.
REQ-011 flush  input  1  squash the instruction currently in the unit.
REQ-012 stall_out  output  1  upstream SHALL hold in_* stable while high.
REQ-013 mem_req / mem_we  output  1 / 1  memory request / write strobe.
REQ-014 mem_be  output  4  byte-lane enables.
REQ-015 mem_addr  output  32  word address, bits [1:0] forced 00.
REQ-016 mem_wdata  output  32  lane-aligned store data.
REQ-017 mem_rdata / mem_ready  input  32 / 1  read word / completion, sampled in BUSY.
REQ-018 wb_valid / wb_data / wb_dest  output  1 / 32 / 5  registered MEM/WB result.
REQ-019 exc_misalign / exc_bus / exc_addr  output  1 / 1 / 32  one-cycle exception pulses and faulting byte address.

Function
REQ-020 States SHALL be IDLE and BUSY; stall_out SHALL equal (state==BUSY).
REQ-021 IDLE, in_valid=1, in_mem=0, flush=0: next cycle wb_valid=1, wb_data=in_res, wb_dest=in_dest (latency 1).
REQ-022 IDLE, in_valid=1, in_mem=1, flush=0, access legal: latch request, enter BUSY; mem_req=1 for every BUSY cycle, with mem_addr/mem_we/mem_be/mem_wdata constant.
REQ-023 Byte enables: SW 1111; SH 0011 if addr[1]=0 else 1100; SB 0001<<addr[1:0]; loads 1111 with mem_we=0.
REQ-024 Store data: SB replicates byte to all four lanes; SH replicates halfword to both halves; SW unchanged.
REQ-025 BUSY with mem_ready=1: return to IDLE next edge; a load SHALL then present wb_valid=1 with extended data, a store SHALL present wb_valid=0.
REQ-026 Load extension: LW whole word; LH/LHU select halfword by addr[1]; LB/LBU select byte by addr[1:0]; LH/LB sign-extend, LHU/LBU zero-extend.
REQ-027 Minimum memory-op latency: accept at edge N, mem_req in cycle N+1, mem_ready in N+1 gives wb_valid in cycle N+2.
REQ-028 BUSY cycle counter SHALL reset on entry; if TIMEOUT_CYCLES cycles elapse without mem_ready: drop mem_req, pulse exc_bus with exc_addr=latched address, wb_valid=0, return to IDLE.
REQ-029 flush in IDLE discards the input and gives wb_valid=0 next cycle; flush in BUSY SHALL NOT abort the handshake but SHALL suppress the resulting wb_valid.
REQ-030 wb_valid SHALL be a single-cycle pulse per completed instruction; no new input is accepted in BUSY.
REQ-031 mem_ready sampled while IDLE SHALL be ignored.

Reset
REQ-032 rst SHALL force IDLE, counter 0, and deassert stall_out, mem_req, mem_we, mem_be, wb_valid, exc_misalign, exc_bus; zero mem_addr, mem_wdata, wb_data, wb_dest, exc_addr.
REQ-033 rst during BUSY SHALL drop mem_req in the following cycle and report no exception or writeback.

Configuration
REQ-034 Macro MISALIGN_TRAP_EN defined: LW/SW with addr[1:0]!=00, or LH/LHU/SH with addr[0]=1, SHALL issue no mem_req, stay IDLE, and pulse exc_misalign with exc_addr=in_addr in the next cycle, with wb_valid=0.
REQ-035 MISALIGN_TRAP_EN undefined: exc_misalign tied 0; address bits unused by the access width are ignored and the access proceeds per REQ-023/026.

Verification
REQ-036 SB addr=0x0000_0013, wdata=0x0000_00A5, ready after 1 cycle -> mem_be=1000, mem_addr=0x10, mem_wdata=0xA5A5A5A5, no wb_valid.
REQ-037 LB addr=0x21, rdata=0x1234_80FF -> wb_data=0xFFFF_FF80; LBU same -> 0x0000_0080; wb_valid at N+2.
REQ-038 LH addr=0x42, ready after 5 cycles, rdata=0x8001_7FFF -> stall_out high 5 cycles, wb_data=0xFFFF_8001.
REQ-039 LW with no mem_ready, TIMEOUT_CYCLES=4 -> exc_bus pulse after 4 BUSY cycles, exc_addr=request address, back to IDLE.
REQ-040 With MISALIGN_TRAP_EN: SW addr=0x102 -> no mem_req, exc_misalign=1 one cycle, exc_addr=0x102; without: mem_addr=0x100, be=1111.
REQ-041 rst asserted in second BUSY cycle of LW -> mem_req=0 next cycle, wb_valid and exceptions remain 0; flush during BUSY -> handshake completes, wb_valid=0.
